// File: rtl/bip_rate_gen.sv
// Purpose : nearest-of-N proximity beep generator; picks the closest channel,
//           maps its distance to a beep-rate band (1..11 Hz, continuous, or silent)
//           with farther-band hysteresis, and drives a glitch-free buzzer enable.
// Latency : dst_valid -> latch 1 cycle, arbitration +1, band/hysteresis +1, FSM +1.
// Backpr. : none; strobes are always accepted, the newest distance per channel wins.
// Ports   : clk, n_rst (async active-low), dst/dst_valid (packed per-channel
//           distances and strobes), enable (global gate), bip_en (buzzer enable),
//           nearest_ch (selected channel index), cont_tone (continuous-tone state).
module bip_rate_gen #(
    parameter int N_CH     = 2,
    parameter int DST_W    = 12,
    parameter int CLK_HZ   = 50000000,
    parameter int CNT_W    = 26,
    parameter int CONT_DST = 30,
    parameter int HYST     = 5
) (
    input  logic                                      clk,
    input  logic                                      n_rst,
    input  logic [N_CH*DST_W-1:0]                     dst,
    input  logic [N_CH-1:0]                           dst_valid,
    input  logic                                      enable,
    output logic                                      bip_en,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] nearest_ch,
    output logic                                      cont_tone
);

    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_OFF, S_ON, S_CONT} state_t;

    logic [DST_W-1:0] d_q [N_CH];
    logic [DST_W-1:0] d_min;
    logic [DST_W-1:0] min_d;
    logic [CH_W-1:0]  min_i;
    logic [DST_W-1:0] d_hyst;
    logic [3:0]       b_now;
    logic [3:0]       b_hyst;
    logic [3:0]       tgt;
    logic [3:0]       tgt_nxt;
    logic [3:0]       act;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] per;
    logic [CNT_W-1:0] off_last;
    logic [CNT_W-1:0] on_last;
    state_t           state;

    // Band 0 = silent, 1..11 = beep rate in Hz, 12 = continuous tone.
    // Each band covers (lower, upper]; the continuous zone overrides band 11.
    function automatic logic [3:0] band(input logic [DST_W-1:0] d);
        logic [31:0] v;
        v = 32'(d);
        if (v > 32'd700)                  band = 4'd0;
        else if (v <= 32'(CONT_DST))      band = 4'd12;
        else if (v <= 32'd50)             band = 4'd11;
        else if (v <= 32'd70)             band = 4'd10;
        else if (v <= 32'd100)            band = 4'd9;
        else if (v <= 32'd120)            band = 4'd8;
        else if (v <= 32'd150)            band = 4'd7;
        else if (v <= 32'd200)            band = 4'd6;
        else if (v <= 32'd250)            band = 4'd5;
        else if (v <= 32'd300)            band = 4'd4;
        else if (v <= 32'd400)            band = 4'd3;
        else if (v <= 32'd500)            band = 4'd2;
        else                              band = 4'd1;
    endfunction

    // Beep period in clock cycles; every entry folds to a constant at elaboration.
    function automatic logic [CNT_W-1:0] period(input logic [3:0] k);
        case (k)
            4'd1:    period = CNT_W'(CLK_HZ / 1);
            4'd2:    period = CNT_W'(CLK_HZ / 2);
            4'd3:    period = CNT_W'(CLK_HZ / 3);
            4'd4:    period = CNT_W'(CLK_HZ / 4);
            4'd5:    period = CNT_W'(CLK_HZ / 5);
            4'd6:    period = CNT_W'(CLK_HZ / 6);
            4'd7:    period = CNT_W'(CLK_HZ / 7);
            4'd8:    period = CNT_W'(CLK_HZ / 8);
            4'd9:    period = CNT_W'(CLK_HZ / 9);
            4'd10:   period = CNT_W'(CLK_HZ / 10);
            4'd11:   period = CNT_W'(CLK_HZ / 11);
            default: period = CNT_W'(CLK_HZ);
        endcase
    endfunction

    // Per-channel distance latches; all-ones reads as "far away" (silent).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < N_CH; i++) d_q[i] <= '1;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (dst_valid[i]) d_q[i] <= dst[i*DST_W +: DST_W];
        end
    end

    // Strict less-than while scanning upward keeps the lowest index on ties.
    always_comb begin
        min_d = d_q[0];
        min_i = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (d_q[i] < min_d) begin
                min_d = d_q[i];
                min_i = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            d_min      <= '1;
            nearest_ch <= '0;
        end else begin
            d_min      <= min_d;
            nearest_ch <= min_i;
        end
    end

    // Nearer bands are taken at once; a farther band only once the distance
    // has moved HYST cm past the boundary.
    always_comb begin
        d_hyst  = (d_min > DST_W'(HYST)) ? d_min - DST_W'(HYST) : '0;
        b_now   = band(d_min);
        b_hyst  = band(d_hyst);
        tgt_nxt = tgt;
        if (b_now > tgt)       tgt_nxt = b_now;
        else if (b_hyst < tgt) tgt_nxt = b_hyst;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) tgt <= '0;
        else        tgt <= tgt_nxt;
    end

    assign per      = period(act);
    assign off_last = (per >> 1) - CNT_W'(1);
    assign on_last  = per - (per >> 1) - CNT_W'(1);

    // act only changes at a period boundary (or on leaving IDLE/CONT), so a
    // beep in progress is never cut short or stretched by a new target.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            act       <= '0;
            bip_en    <= 1'b0;
            cont_tone <= 1'b0;
        end else if (!enable) begin
            state     <= S_IDLE;
            cnt       <= '0;
            bip_en    <= 1'b0;
            cont_tone <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tgt == 4'd12) begin
                        state     <= S_CONT;
                        bip_en    <= 1'b1;
                        cont_tone <= 1'b1;
                    end else if (tgt != 4'd0) begin
                        act   <= tgt;
                        cnt   <= '0;
                        state <= S_OFF;
                    end
                end
                S_OFF: begin
                    if (cnt == off_last) begin
                        cnt    <= '0;
                        state  <= S_ON;
                        bip_en <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt == on_last) begin
                        cnt <= '0;
                        if (tgt == 4'd0) begin
                            state  <= S_IDLE;
                            bip_en <= 1'b0;
                        end else if (tgt == 4'd12) begin
                            state     <= S_CONT;
                            cont_tone <= 1'b1;
                        end else begin
                            act    <= tgt;
                            state  <= S_OFF;
                            bip_en <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_CONT: begin
                    if (tgt != 4'd12) begin
                        cont_tone <= 1'b0;
                        bip_en    <= 1'b0;
                        cnt       <= '0;
                        if (tgt == 4'd0) begin
                            state <= S_IDLE;
                        end else begin
                            act   <= tgt;
                            state <= S_OFF;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bip_rate_gen.sv
// Bench for bip_rate_gen at CLK_HZ=1100: a table of two-channel distance
// vectors with expected first-rise latency, hand-written multi-cycle sequences,
// and a long random run, all cross-checked every cycle against a behavioural model.
module tb_bip_rate_gen;

    localparam int N_CH     = 2;
    localparam int DST_W    = 12;
    localparam int CLK_HZ   = 1100;
    localparam int CNT_W    = 12;
    localparam int CONT_DST = 30;
    localparam int HYST     = 5;
    localparam int CH_W     = 1;
    localparam int FAR      = (1 << DST_W) - 1;

    logic                  clk = 1'b0;
    logic                  n_rst = 1'b0;
    logic [N_CH*DST_W-1:0] dst = '1;
    logic [N_CH-1:0]       dst_valid = '0;
    logic                  enable = 1'b1;
    logic                  bip_en;
    logic [CH_W-1:0]       nearest_ch;
    logic                  cont_tone;

    bip_rate_gen #(
        .N_CH(N_CH), .DST_W(DST_W), .CLK_HZ(CLK_HZ), .CNT_W(CNT_W),
        .CONT_DST(CONT_DST), .HYST(HYST)
    ) dut (
        .clk(clk), .n_rst(n_rst), .dst(dst), .dst_valid(dst_valid),
        .enable(enable), .bip_en(bip_en), .nearest_ch(nearest_ch),
        .cont_tone(cont_tone)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    function automatic void check(string name, int got, int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    endfunction

    // ---------------- behavioural reference model ----------------
    // Output modelled as a position within the current beep period: low for
    // the first half (truncated), high for the rest.
    int md [N_CH];
    int mdmin, mnear, mtgt;
    int mmode;          // 0 silent, 1 beeping, 2 continuous
    int mpos, mper;

    function automatic int band_of(int d);
        int ub [11] = '{700, 500, 400, 300, 250, 200, 150, 120, 100, 70, 50};
        int b = 0;
        if (d <= CONT_DST) return 12;
        for (int i = 0; i < 11; i++) if (d <= ub[i]) b = i + 1;
        return b;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N_CH; i++) md[i] = FAR;
        mdmin = FAR; mnear = 0; mtgt = 0;
        mmode = 0; mpos = 0; mper = 1;
    endfunction

    function automatic void model_step();
        int nd [N_CH];
        int ndmin, nnear, ntgt, b, hb;
        if (!n_rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < N_CH; i++)
            nd[i] = dst_valid[i] ? int'(dst[i*DST_W +: DST_W]) : md[i];
        ndmin = md[0]; nnear = 0;
        for (int i = 1; i < N_CH; i++)
            if (md[i] < ndmin) begin ndmin = md[i]; nnear = i; end
        b  = band_of(mdmin);
        hb = band_of((mdmin > HYST) ? mdmin - HYST : 0);
        ntgt = (b > mtgt) ? b : ((hb < mtgt) ? hb : mtgt);
        if (!enable) begin
            mmode = 0; mpos = 0;
        end else begin
            case (mmode)
                0: begin
                    if (mtgt == 12) mmode = 2;
                    else if (mtgt != 0) begin mmode = 1; mper = CLK_HZ / mtgt; mpos = 0; end
                end
                1: begin
                    if (mpos == mper - 1) begin
                        if (mtgt == 0) mmode = 0;
                        else if (mtgt == 12) mmode = 2;
                        else begin mper = CLK_HZ / mtgt; mpos = 0; end
                    end else mpos++;
                end
                default: begin
                    if (mtgt != 12) begin
                        if (mtgt == 0) mmode = 0;
                        else begin mmode = 1; mper = CLK_HZ / mtgt; mpos = 0; end
                    end
                end
            endcase
        end
        md = nd; mdmin = ndmin; mnear = nnear; mtgt = ntgt;
    endfunction

    function automatic int exp_bip();
        if (mmode == 2) return 1;
        if (mmode == 1 && mpos >= mper / 2) return 1;
        return 0;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
        check("bip_en_model", int'(bip_en), exp_bip());
        check("cont_tone_model", int'(cont_tone), (mmode == 2) ? 1 : 0);
        check("nearest_ch_model", int'(nearest_ch), mnear);
    endtask

    task automatic strobe(input int ch, input int d);
        dst[ch*DST_W +: DST_W] = DST_W'(d);
        dst_valid = '0;
        dst_valid[ch] = 1'b1;
        tick();
        dst_valid = '0;
    endtask

    task automatic strobe2(input int d0, input int d1);
        dst[0 +: DST_W]     = DST_W'(d0);
        dst[DST_W +: DST_W] = DST_W'(d1);
        dst_valid = '1;
        tick();
        dst_valid = '0;
    endtask

    // Ticks until bip_en equals v; lat = cycles from call, -1 if budget expired.
    task automatic wait_level(input logic v, input int budget, output int lat);
        int n = 0;
        while (bip_en !== v && n < budget) begin
            tick();
            n++;
        end
        lat = (bip_en === v) ? n : -1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        dst_valid = '0;
        #1;
        model_reset();
        tick();
        tick();
        n_rst = 1'b1;
    endtask

    typedef struct {
        int d0;
        int d1;
        int near;
        int lat;    // cycles from the edge before the strobe to the first rise, -1 = silent
        int cont;
    } vec_t;

    vec_t tbl [13];
    int   lat, c0, t;

    initial begin
        tbl[0]  = '{40,   FAR, 0,  54, 0};
        tbl[1]  = '{600,  450, 1, 279, 0};
        tbl[2]  = '{50,   FAR, 0,  54, 0};
        tbl[3]  = '{51,   FAR, 0,  59, 0};
        tbl[4]  = '{30,   FAR, 0,   4, 1};
        tbl[5]  = '{31,   FAR, 0,  54, 0};
        tbl[6]  = '{700,  FAR, 0, 554, 0};
        tbl[7]  = '{701,  FAR, 0,  -1, 0};
        tbl[8]  = '{FAR,  100, 1,  65, 0};
        tbl[9]  = '{120,  120, 0,  72, 0};
        tbl[10] = '{250,  900, 0, 114, 0};
        tbl[11] = '{0,      5, 0,   4, 1};
        tbl[12] = '{301,  299, 1, 141, 0};

        model_reset();
        #2;
        check("reset_bip_en", int'(bip_en), 0);
        check("reset_cont_tone", int'(cont_tone), 0);
        check("reset_nearest_ch", int'(nearest_ch), 0);
        do_reset();

        // ---- table: first-rise latency, selected channel, tone type ----
        for (int i = 0; i < 13; i++) begin
            do_reset();
            c0 = cyc;
            strobe2(tbl[i].d0, tbl[i].d1);
            wait_level(1'b1, 1200, lat);
            t = (lat < 0) ? -1 : cyc - c0;
            check($sformatf("vec%0d_latency", i), t, tbl[i].lat);
            check($sformatf("vec%0d_nearest", i), int'(nearest_ch), tbl[i].near);
            check($sformatf("vec%0d_cont", i), int'(cont_tone), tbl[i].cont);
        end

        // ---- 2 Hz pattern, tie back to channel 0 ----
        do_reset();
        strobe2(600, 450);
        wait_level(1'b1, 600, lat);
        c0 = cyc;
        wait_level(1'b0, 600, lat);
        check("two_ch_high", (lat < 0) ? -1 : cyc - c0, 275);
        c0 = cyc;
        wait_level(1'b1, 600, lat);
        check("two_ch_low", (lat < 0) ? -1 : cyc - c0, 275);
        strobe(0, 450);
        tick();
        check("tie_nearest", int'(nearest_ch), 0);

        // ---- hysteresis: 503 holds 2 Hz, 506 drops to 1 Hz at the boundary ----
        do_reset();
        strobe(0, 450);
        wait_level(1'b1, 600, lat);
        c0 = cyc;
        strobe(0, 503);
        wait_level(1'b0, 600, lat);
        check("hyst503_high", (lat < 0) ? -1 : cyc - c0, 275);
        c0 = cyc;
        wait_level(1'b1, 600, lat);
        check("hyst503_low", (lat < 0) ? -1 : cyc - c0, 275);
        c0 = cyc;
        strobe(0, 506);
        wait_level(1'b0, 600, lat);
        check("hyst506_high_kept", (lat < 0) ? -1 : cyc - c0, 275);
        c0 = cyc;
        wait_level(1'b1, 1200, lat);
        check("hyst506_low_1hz", (lat < 0) ? -1 : cyc - c0, 550);
        c0 = cyc;
        wait_level(1'b0, 1200, lat);
        check("hyst506_high_1hz", (lat < 0) ? -1 : cyc - c0, 550);

        // ---- continuous tone and exit into a 10 Hz OFF phase ----
        do_reset();
        strobe(0, 25);
        wait_level(1'b1, 20, lat);
        check("cont_on", int'(cont_tone), 1);
        repeat (30) tick();
        check("cont_held", int'(bip_en), 1);
        strobe(0, 60);
        wait_level(1'b0, 20, lat);
        check("cont_exit", int'(cont_tone), 0);
        c0 = cyc;
        wait_level(1'b1, 200, lat);
        check("cont_exit_off55", (lat < 0) ? -1 : cyc - c0, 55);

        // ---- silence at boundary, enable gating ----
        do_reset();
        strobe(0, 40);
        wait_level(1'b1, 200, lat);
        c0 = cyc;
        strobe(0, 800);
        wait_level(1'b0, 200, lat);
        check("silence_on_kept", (lat < 0) ? -1 : cyc - c0, 50);
        wait_level(1'b1, 300, lat);
        check("silence_hold", lat, -1);
        strobe(0, 40);
        wait_level(1'b1, 200, lat);
        repeat (10) tick();
        enable = 1'b0;
        tick();
        check("enable_off", int'(bip_en), 0);
        repeat (20) tick();
        enable = 1'b1;
        c0 = cyc;
        wait_level(1'b1, 200, lat);
        check("enable_fresh_off", (lat < 0) ? -1 : cyc - c0, 51);

        // ---- asynchronous reset mid-ON ----
        repeat (5) tick();
        #2;
        n_rst = 1'b0;
        #1;
        check("async_rst_bip", int'(bip_en), 0);
        model_reset();
        tick();
        tick();
        n_rst = 1'b1;
        wait_level(1'b1, 300, lat);
        check("post_rst_silent", lat, -1);

        // ---- random run against the model ----
        do_reset();
        for (int k = 0; k < 20000; k++) begin
            int r;
            r = int'($urandom_range(0, 299));
            if (r < 2) begin
                int ub [11] = '{700, 500, 400, 300, 250, 200, 150, 120, 100, 70, 50};
                int d;
                if ($urandom_range(0, 1) == 0) d = int'($urandom_range(0, 900));
                else d = ub[$urandom_range(0, 10)] + int'($urandom_range(0, 12)) - 6;
                if (d < 0) d = 0;
                if (r == 0) strobe(int'($urandom_range(0, N_CH - 1)), d);
                else strobe2(d, int'($urandom_range(0, 900)));
            end else if (r == 2) begin
                enable = ($urandom_range(0, 3) != 0);
                tick();
            end else begin
                tick();
            end
        end
        enable = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bip_rate_gen.md
# bip_rate_gen

Parametrised multi-channel proximity beep generator for the parking-sensor datapath. It takes N_CH distance readings, in centimetres, from the ranging front-ends and selects the nearest one. It maps that distance to a beep-rate band, with hysteresis, and drives `bip_en` to the buzzer driver. Relative to the single-channel generator, it adds channel arbitration, a continuous-tone zone, glitch-free rate changes at period boundaries, and a global enable.

## Interface
Parameters:
- `N_CH`, 2: number of distance channels (1..8).
- `DST_W`, 12: distance width, unsigned cm.
- `CLK_HZ`, 50000000: clock frequency; all periods are derived from it at elaboration.
- `CNT_W`, 26: period counter width; must hold CLK_HZ.
- `CONT_DST`, 30: distance ≤ CONT_DST gives a continuous tone.
- `HYST`, 5: hysteresis in cm, applied only to moves toward a farther band.

Ports:
- `clk`  in  1  system clock.
- `n_rst`  in  1  reset; asynchronous, active-low.
- `dst`  in  N_CH*DST_W  packed distances; channel i occupies `[i*DST_W +: DST_W]`.
- `dst_valid`  in  N_CH  per-channel strobe; a 1-cycle pulse latches that channel's distance.
- `enable`  in  1  global enable; low forces silence.
- `bip_en`  out  1  buzzer enable.
- `nearest_ch`  out  $clog2(N_CH) (min 1)  index of the channel currently selected.
- `cont_tone`  out  1  high while in continuous-tone state.

## Operation
- **Channel latch:** per-channel register `d_i`, reset to all-ones (meaning silent). On `dst_valid[i]`, `d_i` ← new distance.
- **Arbitration:** registered minimum over `d_i`. Ties go to the lowest index. The result feeds `nearest_ch` and `d_min`.
- **Band map, `band(d)`:** band 0 = silent (d > 700). Bands 1..11 map to 1..11 Hz with upper bounds 700, 500, 400, 300, 250, 200, 150, 120, 100, 70, 50 (each band's range is lower < d ≤ upper). Band 12 = continuous (d ≤ CONT_DST), which takes precedence over band 11.
- **Period:** `P_k = CLK_HZ / k`, integer-truncated localparams. Off phase = `P_k/2` cycles, on phase = `P_k − P_k/2` cycles.
- **Hysteresis:** register `tgt` (reset 0), updated every cycle.
  - If `band(d_min) > tgt`, then `tgt ← band(d_min)`; a nearer band is taken immediately.
  - Else if `band(sat(d_min − HYST)) < tgt`, then `tgt ← band(sat(d_min − HYST))`.
  - Otherwise `tgt` holds. Subtraction saturates at 0.
- **FSM states:** IDLE, OFF, ON, CONT. The counter `cnt` is CNT_W wide. The active band `act` is loaded from `tgt` only at the transitions listed below.
  - **IDLE:** `bip_en`=0. If `enable` and `tgt` is 1..11: `act←tgt`, `cnt←0`, go to OFF. If `enable` and `tgt`=12: go to CONT.
  - **OFF:** `bip_en`=0. `cnt` increments. When `cnt = P_act/2 − 1`: `cnt←0`, go to ON.
  - **ON:** `bip_en`=1. `cnt` increments. When `cnt = P_act − P_act/2 − 1` (period boundary), sample `tgt`:
    - 0 → IDLE.
    - 12 → CONT.
    - otherwise `act←tgt`, `cnt←0`, go to OFF.
  - **CONT:** `bip_en`=1. When `tgt ≠ 12`: if `tgt`=0 go to IDLE; else `act←tgt`, `cnt←0`, go to OFF.
- `enable` low in any state → IDLE on the next edge, `cnt←0`. Channel latches and `tgt` keep updating.
- Rate changes never truncate or stretch a period in progress. The only exceptions are `enable` deassertion, reset, and entry/exit of CONT.

## Timing
- Reset values: `bip_en`=0, `cont_tone`=0, `nearest_ch`=0; state IDLE, `cnt`=0, `tgt`=0, `act`=0, all `d_i`=all-ones.
- Pipeline from `dst_valid` at edge 0:
  - `d_i` updated at edge 1.
  - `d_min`/`nearest_ch` updated at edge 2.
  - `tgt` updated at edge 3.
  - IDLE→OFF or CONT at edge 4.
  - `bip_en` for CONT rises after edge 4.
- `bip_en` and `cont_tone` are registered directly from state; there is no combinational path from inputs.
- Simultaneous `dst_valid` on several channels: all are latched in the same cycle.
- Distance exactly on a boundary (e.g. 50) belongs to the farther band's upper bound, i.e. 50 → band 11 (11 Hz).
- `n_rst` asserted mid-period: every register returns to its reset value immediately (asynchronous). After release, the pipeline restarts from the reset values.

## Test plan
Benches use `CLK_HZ`=1100, `N_CH`=2, `HYST`=5, `CONT_DST`=30. Resulting periods: P1=1100, P2=550, P11=100.
- **Single channel 40 cm:** ch0=40 pulse → `bip_en` low for 50 cycles, high for 50, repeating; first rise 54 cycles after the strobe edge.
- **Two channels, ch0=600 and ch1=450:** `nearest_ch`=1; 2 Hz pattern of 275 low / 275 high. Then ch0=450 (tie) → `nearest_ch`=0.
- **Hysteresis:** at 2 Hz, set the distance to 503 → stays 2 Hz; set to 506 → 1 Hz (550/550) starts only after the current on phase completes.
- **Continuous tone:** distance 25 → `bip_en` and `cont_tone` held high. Set 60 → `cont_tone` falls and a 10 Hz OFF phase (55 cycles) starts immediately.
- **Silence and enable:** distance 800 → `bip_en` ends low at the next period boundary, then stays 0. Deassert `enable` mid-ON → `bip_en`=0 next cycle. Reassert → a fresh OFF phase with `cnt`=0.
- **Async reset mid-ON:** assert `n_rst` low → `bip_en` drops 0 without a clock edge. After release, silent until a new `dst_valid`.
